uart_line_reader: RTL



---
 rtl/uart_line_pkg.sv | 21 ++
 rtl/uart_line_buffer_ram.sv | 42 ++++
 rtl/uart_line_reader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_line_pkg.sv
// Shared types for the UART line reader: FSM state encoding and control characters.
// No logic; no latency or backpressure of its own.
// Imported by uart_line_reader.
package uart_line_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_WAIT,
        ST_PROC,
        ST_ECHO,
        ST_GAP,
        ST_HOLD
    } state_e;

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_DEL = 8'h7F;

endpackage

// File: rtl/uart_line_buffer_ram.sv
// Line storage: MAX_LEN x DATA_BITS, one write port, registered read port.
// Latency: read data valid one cycle after the address; writes land on the clock edge.
// Backpressure: none; contents are not reset.
module line_buffer_ram #(
    parameter int DATA_BITS = 8,
    parameter int MAX_LEN   = 32,
    parameter int ADDR_W    = $clog2(MAX_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem_q [0:MAX_LEN-1];
    logic [DATA_BITS-1:0] rd_data_d;
    logic [DATA_BITS-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_line_reader.sv
// Line assembler behind the UART rx FIFO with backspace handling; optional echo via UART_LINE_ECHO_EN.
// Latency: RD_LAT+3 cycles per byte, plus ECHO/GAP and any tx_full stall when echo is built in.
// Backpressure: no pops while a completed line is held; echo waits while tx_full is high.
module uart_line_reader
    import uart_line_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int MAX_LEN   = 32,
    parameter int RD_LAT    = 3,
    parameter int LEN_W     = $clog2(MAX_LEN + 1),
    parameter int ADDR_W    = $clog2(MAX_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_empty,
    output logic                 rx_pop,
    output logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_full,
    output logic                 tx_push,
    output logic                 line_ready,
    output logic [LEN_W-1:0]     line_len,
    output logic                 line_ovf,
    input  logic                 line_ack,
    input  logic [ADDR_W-1:0]    line_rd_addr,
    output logic [DATA_BITS-1:0] line_rd_data
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] cur_q, cur_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 ovf_q, ovf_d;

    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic                 is_term;
    logic                 is_bs;
    logic                 line_done;

`ifdef UART_LINE_ECHO_EN
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
`endif

    assign is_term = (cur_q == DATA_BITS'(CH_CR)) || (cur_q == DATA_BITS'(CH_LF));
    assign is_bs   = (cur_q == DATA_BITS'(CH_BS)) || (cur_q == DATA_BITS'(CH_DEL));
    assign wr_addr = len_q[ADDR_W-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_d     = cur_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        wr_en     = 1'b0;
        line_done = 1'b0;
`ifdef UART_LINE_ECHO_EN
        done_d    = done_q;
        tx_data_d = tx_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_empty) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                cnt_d   = CNT_W'(RD_LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    cur_d   = rx_data;
                    state_d = ST_PROC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PROC: begin
                // Empty terminators are dropped so CRLF and blank lines yield no line.
                if (is_term) begin
                    line_done = (len_q != '0);
                end else if (is_bs) begin
                    if (len_q != '0) begin
                        len_d = len_q - LEN_W'(1);
                    end
                end else if (len_q < LEN_W'(MAX_LEN)) begin
                    wr_en = 1'b1;
                    len_d = len_q + LEN_W'(1);
                end else begin
                    ovf_d = 1'b1;
                end
`ifdef UART_LINE_ECHO_EN
                done_d    = line_done;
                tx_data_d = cur_q;
                state_d   = ST_ECHO;
`else
                state_d   = line_done ? ST_HOLD : ST_IDLE;
`endif
            end
`ifdef UART_LINE_ECHO_EN
            ST_ECHO: begin
                if (!tx_full) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = done_q ? ST_HOLD : ST_IDLE;
            end
`endif
            ST_HOLD: begin
                if (line_ack) begin
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef UART_LINE_ECHO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q    <= 1'b0;
            tx_data_q <= '0;
        end else begin
            done_q    <= done_d;
            tx_data_q <= tx_data_d;
        end
    end

    // tx_data is loaded on entry to ECHO, so it is stable before and after the push edge.
    assign tx_data = tx_data_q;
    assign tx_push = (state_q == ST_ECHO) && !tx_full;
`else
    logic unused_tx_full;
    assign unused_tx_full = tx_full;
    assign tx_data        = '0;
    assign tx_push        = 1'b0;
`endif

    assign rx_pop     = (state_q == ST_POP);
    assign line_ready = (state_q == ST_HOLD);
    assign line_len   = len_q;
    assign line_ovf   = ovf_q;

    line_buffer_ram #(
        .DATA_BITS (DATA_BITS),
        .MAX_LEN   (MAX_LEN),
        .ADDR_W    (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (cur_q),
        .rd_addr (line_rd_addr),
        .rd_data (line_rd_data)
    );

endmodule
